// File: rtl/pll_dyn_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration sequencer.
package pll_dyn_ctrl_pkg;

    localparam int DIV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RST       = 2'd1,
        ST_WAIT_LOCK = 2'd2,
        ST_STABLE    = 2'd3
    } state_t;

endpackage

// File: rtl/pll_dyn_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Sequencer owning the PLL reset pin and dynamic dividers: applies settings,
// pulses reset, waits for a stable lock and reports locked/done/err status.
module pll_dyn_ctrl
    import pll_dyn_ctrl_pkg::*;
#(
    parameter int NOUT          = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int DEF_IDIV      = 2,
    parameter int DEF_FDIV      = 32,
    parameter int DEF_ODIV      = 100,
    parameter int DEF_DUTY      = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DIV_W-1:0]        req_idiv,
    input  logic [DIV_W-1:0]        req_fdiv,
    input  logic [NOUT*DIV_W-1:0]   req_odiv,
    input  logic [NOUT*DIV_W-1:0]   req_duty,
    input  logic                    pll_lock,
    output logic                    pll_rst,
    output logic [DIV_W-1:0]        dyn_idiv,
    output logic [DIV_W-1:0]        dyn_fdiv,
    output logic [NOUT*DIV_W-1:0]   dyn_odiv,
    output logic [NOUT*DIV_W-1:0]   dyn_duty,
    output logic                    locked,
    output logic                    done,
    output logic                    err,
    output logic                    fail,
    output logic                    lock_lost,
    output logic [1:0]              retry_cnt
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);

    logic lock_s;

    lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [DIV_W-1:0]        idiv_q, idiv_d, fdiv_q, fdiv_d;
    logic [NOUT*DIV_W-1:0]   odiv_q, odiv_d, duty_q, duty_d;
    logic                    locked_q, locked_d, done_q, done_d, err_q, err_d;
    logic                    fail_q, fail_d, lock_lost_q, lock_lost_d;
    logic [1:0]              retry_q, retry_d;
    logic [RW-1:0]           rst_cnt_q, rst_cnt_d;
    logic [15:0]             to_cnt_q, to_cnt_d;
    logic [SW-1:0]           stab_cnt_q, stab_cnt_d;
    logic                    req_zero;
    logic                    retry;

    always_comb begin
        req_zero = (req_idiv == '0) || (req_fdiv == '0);
        for (int k = 0; k < NOUT; k++) begin
            if (req_odiv[k*DIV_W +: DIV_W] == '0 || req_duty[k*DIV_W +: DIV_W] == '0) begin
                req_zero = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pll_rst_d   = pll_rst_q;
        idiv_d      = idiv_q;
        fdiv_d      = fdiv_q;
        odiv_d      = odiv_q;
        duty_d      = duty_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        fail_d      = fail_q;
        lock_lost_d = lock_lost_q;
        retry_d     = retry_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        retry       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_zero) begin
                        err_d = 1'b1;
                    end else begin
                        idiv_d      = req_idiv;
                        fdiv_d      = req_fdiv;
                        odiv_d      = req_odiv;
                        duty_d      = req_duty;
                        locked_d    = 1'b0;
                        fail_d      = 1'b0;
                        lock_lost_d = 1'b0;
                        retry_d     = 2'd0;
                        rst_cnt_d   = '0;
                        pll_rst_d   = 1'b1;
                        state_d     = ST_RST;
                    end
                end else if (locked_q && !lock_s) begin
                    locked_d    = 1'b0;
                    lock_lost_d = 1'b1;
                end
            end
            ST_RST: begin
                pll_rst_d = 1'b1;
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    pll_rst_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (lock_s) begin
                    stab_cnt_d = '0;
                    state_d    = ST_STABLE;
                end else if (to_cnt_q == TO_LAST) begin
                    retry = 1'b1;
                end
            end
            ST_STABLE: begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (!lock_s) begin
                    stab_cnt_d = '0;
                    state_d    = ST_WAIT_LOCK;
                end else if (stab_cnt_q + SW'(1) == SW'(STABLE_CYCLES)) begin
                    stab_cnt_d = '0;
                    locked_d   = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    retry = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A timed-out attempt either restarts the reset pulse or gives up for good.
        if (retry) begin
            if (int'(retry_q) + 1 < MAX_RETRY) begin
                retry_d   = retry_q + 2'd1;
                rst_cnt_d = '0;
                pll_rst_d = 1'b1;
                state_d   = ST_RST;
            end else begin
                fail_d    = 1'b1;
                err_d     = 1'b1;
                locked_d  = 1'b0;
                pll_rst_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end
    end

    // Ready opens only after a full cycle settled in IDLE, so it trails done/err.
    assign req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST;
            req_ready_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            idiv_q      <= DIV_W'(DEF_IDIV);
            fdiv_q      <= DIV_W'(DEF_FDIV);
            odiv_q      <= {NOUT{DIV_W'(DEF_ODIV)}};
            duty_q      <= {NOUT{DIV_W'(DEF_DUTY)}};
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= 2'd0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stab_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            pll_rst_q   <= pll_rst_d;
            idiv_q      <= idiv_d;
            fdiv_q      <= fdiv_d;
            odiv_q      <= odiv_d;
            duty_q      <= duty_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign pll_rst   = pll_rst_q;
    assign dyn_idiv  = idiv_q;
    assign dyn_fdiv  = fdiv_q;
    assign dyn_odiv  = odiv_q;
    assign dyn_duty  = duty_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl with a behavioural PLL lock model.
module tb_pll_dyn_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_idiv, req_fdiv;
    logic [19:0] req_odiv, req_duty;
    logic        pll_lock;
    logic        pll_rst;
    logic [9:0]  dyn_idiv, dyn_fdiv;
    logic [19:0] dyn_odiv, dyn_duty;
    logic        locked, done, err, fail, lock_lost;
    logic [1:0]  retry_cnt;

    pll_dyn_ctrl #(
        .NOUT(2), .RST_CYCLES(16), .LOCK_TIMEOUT(1000), .STABLE_CYCLES(64), .MAX_RETRY(3),
        .DEF_IDIV(2), .DEF_FDIV(32), .DEF_ODIV(100), .DEF_DUTY(100)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_idiv(req_idiv), .req_fdiv(req_fdiv), .req_odiv(req_odiv), .req_duty(req_duty),
        .pll_lock(pll_lock), .pll_rst(pll_rst), .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
        .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .locked(locked), .done(done), .err(err),
        .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic        locked;
        logic        fail;
        logic [1:0]  retry;
        logic        ready;
        logic [9:0]  idiv;
        logic [9:0]  fdiv;
        logic [19:0] odiv;
        logic [19:0] duty;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    // PLL model: lock rises lock_delay cycles after reset release
    logic lock_en;
    logic force_low;
    int   lock_delay;
    int   lcnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pll_rst) lcnt <= 0;
        else if (lcnt < 100000) lcnt <= lcnt + 1;
    end

    assign pll_lock = lock_en && !pll_rst && (lcnt >= lock_delay) && !force_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // pll_rst pulse monitor
    int npulse = 0;
    int width = 0;
    logic prev_rst = 1'b0;
    int widths[$];
    int rseq[$];

    always @(negedge clk) begin
        if (pll_rst) begin
            if (!prev_rst) begin
                npulse = npulse + 1;
                rseq.push_back(int'(retry_cnt));
            end
            width = width + 1;
        end else if (prev_rst) begin
            widths.push_back(width);
            width = 0;
        end
        prev_rst = pll_rst;
    end

    // Output monitor: every done/err pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            chk("done_err_exclusive", {31'd0, done && err}, 0);
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("pulse_kind_err", {31'd0, err}, {31'd0, mon_e.is_err});
                chk("pulse_locked", {31'd0, locked}, {31'd0, mon_e.locked});
                chk("pulse_fail", {31'd0, fail}, {31'd0, mon_e.fail});
                chk("pulse_retry_cnt", {30'd0, retry_cnt}, {30'd0, mon_e.retry});
                chk("pulse_req_ready", {31'd0, req_ready}, {31'd0, mon_e.ready});
                chk("pulse_idiv", {22'd0, dyn_idiv}, {22'd0, mon_e.idiv});
                chk("pulse_fdiv", {22'd0, dyn_fdiv}, {22'd0, mon_e.fdiv});
                chk("pulse_odiv", {12'd0, dyn_odiv}, {12'd0, mon_e.odiv});
                chk("pulse_duty", {12'd0, dyn_duty}, {12'd0, mon_e.duty});
                if (done) last_done_cyc = cyc;
            end
        end
    end

    task automatic push_exp(input logic is_err, input logic lk, input logic fl, input logic [1:0] rc,
                            input logic rdy, input logic [9:0] id, input logic [9:0] fd,
                            input logic [19:0] od, input logic [19:0] du);
        exp_t e;
        e.is_err = is_err; e.locked = lk; e.fail = fl; e.retry = rc; e.ready = rdy;
        e.idiv = id; e.fdiv = fd; e.odiv = od; e.duty = du;
        sbq.push_back(e);
    endtask

    task automatic send(input string name, input logic [9:0] id, input logic [9:0] fd,
                        input logic [19:0] od, input logic [19:0] du);
        int n;
        @(negedge clk);
        req_idiv = id; req_fdiv = fd; req_odiv = od; req_duty = du;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_seen"}, {31'd0, req_ready}, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, sbq.size(), 0);
        sbq.delete();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, pb, wb, rb, gend;
        rst = 1'b1; req_valid = 1'b0;
        req_idiv = '0; req_fdiv = '0; req_odiv = '0; req_duty = '0;
        lock_en = 1'b1; lock_delay = 200; force_low = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pll_rst", {31'd0, pll_rst}, 1);
        chk("rst_idiv", {22'd0, dyn_idiv}, 2);
        chk("rst_fdiv", {22'd0, dyn_fdiv}, 32);
        chk("rst_odiv", {12'd0, dyn_odiv}, {12'd0, 10'd100, 10'd100});
        chk("rst_duty", {12'd0, dyn_duty}, {12'd0, 10'd100, 10'd100});
        chk("rst_flags", {26'd0, locked, done, err, fail, lock_lost, req_ready}, 0);
        chk("rst_retry", {30'd0, retry_cnt}, 0);

        // power-up bring-up
        push_exp(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd2, 10'd32, {10'd100, 10'd100}, {10'd100, 10'd100});
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pll_rst && n < 100);
        chk("pwrup_rst_len", n, 16);
        wait_drain("pwrup", 2000);
        chk("pwrup_locked", {31'd0, locked}, 1);
        chk("pwrup_ready", {31'd0, req_ready}, 1);

        // reconfigure to 200/200
        pb = npulse; wb = widths.size();
        push_exp(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd2, 10'd32, {10'd200, 10'd200}, {10'd200, 10'd200});
        send("req200", 10'd2, 10'd32, {10'd200, 10'd200}, {10'd200, 10'd200});
        chk("req200_odiv_at_accept", {12'd0, dyn_odiv}, {12'd0, 10'd200, 10'd200});
        chk("req200_duty_at_accept", {12'd0, dyn_duty}, {12'd0, 10'd200, 10'd200});
        chk("req200_locked_cleared", {31'd0, locked}, 0);
        wait_drain("req200", 2000);
        chk("req200_pulses", npulse - pb, 1);
        if (widths.size() > wb) chk("req200_width", widths[wb], 16);
        else chk("req200_width_missing", 0, 1);

        // PLL never locks: three attempts then failure
        lock_en = 1'b0;
        pb = npulse; wb = widths.size(); rb = rseq.size();
        push_exp(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 10'd2, 10'd32, {10'd150, 10'd150}, {10'd150, 10'd150});
        send("nolock", 10'd2, 10'd32, {10'd150, 10'd150}, {10'd150, 10'd150});
        wait_drain("nolock", 5000);
        chk("nolock_pulses", npulse - pb, 3);
        for (int i = 0; i < 3; i++) begin
            if (rseq.size() > rb + i) chk($sformatf("nolock_retry%0d", i), rseq[rb + i], i);
            else chk($sformatf("nolock_retry%0d_missing", i), 0, 1);
            if (widths.size() > wb + i) chk($sformatf("nolock_width%0d", i), widths[wb + i], 16);
            else chk($sformatf("nolock_width%0d_missing", i), 0, 1);
        end
        chk("nolock_fail_sticky", {31'd0, fail}, 1);
        chk("nolock_locked", {31'd0, locked}, 0);

        lock_en = 1'b1;
        push_exp(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd2, 10'd32, {10'd100, 10'd100}, {10'd100, 10'd100});
        send("recover", 10'd2, 10'd32, {10'd100, 10'd100}, {10'd100, 10'd100});
        chk("recover_fail_cleared", {31'd0, fail}, 0);
        wait_drain("recover", 2000);

        // lock glitch during stability window
        push_exp(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd3, 10'd40, {10'd120, 10'd120}, {10'd80, 10'd80});
        send("glitch", 10'd3, 10'd40, {10'd120, 10'd120}, {10'd80, 10'd80});
        n = 0;
        while (!pll_lock && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_lock_seen", {31'd0, pll_lock}, 1);
        repeat (32) @(negedge clk);
        force_low = 1'b1;
        repeat (3) @(negedge clk);
        force_low = 1'b0;
        gend = cyc;
        chk("glitch_no_early_done", sbq.size(), 1);
        wait_drain("glitch", 2000);
        chk("glitch_done_delay_ge64", {31'd0, (last_done_cyc - gend) >= 64}, 1);

        // rejected request with a zero divider
        pb = npulse;
        push_exp(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 10'd3, 10'd40, {10'd120, 10'd120}, {10'd80, 10'd80});
        send("zero", 10'd5, 10'd50, {10'd120, 10'd0}, {10'd50, 10'd50});
        wait_drain("zero", 20);
        chk("zero_odiv_kept", {12'd0, dyn_odiv}, {12'd0, 10'd120, 10'd120});
        chk("zero_idiv_kept", {22'd0, dyn_idiv}, 3);
        chk("zero_locked_kept", {31'd0, locked}, 1);
        chk("zero_no_pulse", npulse - pb, 0);

        // lock drops while idle and locked
        pb = npulse;
        force_low = 1'b1;
        repeat (3) @(negedge clk);
        chk("loss_locked", {31'd0, locked}, 0);
        chk("loss_lock_lost", {31'd0, lock_lost}, 1);
        repeat (20) @(negedge clk);
        chk("loss_no_pulse", npulse - pb, 0);
        chk("loss_ready", {31'd0, req_ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
